cic_interpolator: RTL
=====================

// Module: cic_interpolator
// PURPOSE
//  Cascaded Integrator-Comb interpolator: the transmit-direction counterpart of the CIC decimator.
//  - Accepts low-rate signed Q1.15 samples over a valid/ready handshake.
//  - Runs them through Q comb stages and a zero-stuffing upsampler by R = int_factor.
//  - Then runs them through Q integrator stages clocked by the high-rate out_tick strobe.
//  - Emits one rounded, saturated sample per out_tick.
//  - Sits between the baseband source and the DAC-rate filter chain.
// PARAMETERS
//  DATA_WIDTH      16  input/output sample width (signed)
//  DATA_FRAC       15  fractional bits of input/output
//  Q               1   number of comb and integrator stages (1..4)
//  N               1   differential delay of each comb (1 or 2)
//  MAX_INT_FACTOR  16  largest interpolation factor; ACC_WIDTH = DATA_WIDTH + Q*$clog2(N*MAX_INT_FACTOR)
// PORTS
//  clk         in   1             clock
//  rst_n       in   1             asynchronous, active-low reset
//  int_factor  in   5             interpolation factor R: 1,2,4,8,16
//  valid_in    in   1             cic_in valid
//  ready_in    out  1             block can accept cic_in this cycle
//  cic_in      in   DATA_WIDTH    signed low-rate input sample
//  out_tick    in   1             high-rate output strobe, one output sample per tick
//  cic_out     out  DATA_WIDTH    signed interpolated sample
//  valid_out   out  1             cic_out updated (1-cycle pulse)
//  overflow    out  1             pulse with valid_out: result saturated positive
//  underflow   out  1             pulse with valid_out: result saturated negative
//  starve      out  1             pulse: phase-0 tick found no buffered input, zero used
// BEHAVIOUR
//  Reset values:
//  - All outputs reset to 0 except ready_in, which resets to 1.
//  - Comb delay lines, integrators, phase counter, holding buffer and R_q all reset to 0.
//  - Reset mid-operation discards all state immediately; the first post-reset tick is phase 0.
//  Input buffer (one entry):
//  - ready_in = ~buf_full.
//  - valid_in && ready_in loads cic_in and sets buf_full.
//  - A phase-0 out_tick consumes the buffer.
//  - Load and consume in the same cycle: the consumed value is the old entry, and the buffer stays full with the new one.
//  Phase counter ph (0..R_q-1):
//  - Advances only on out_tick.
//  - Wraps to 0 when ph == R_q-1.
//  - R = 1 means every tick is phase 0.
//  - int_factor is sampled into R_q only on a phase-0 tick, so a mid-frame change takes effect at the next frame.
//  - Illegal int_factor values (not a power of two, 0, or >MAX) are treated as 1.
//  Comb section (low rate):
//  - Updates only on a phase-0 tick.
//  - Stage input x is the buffer entry, or 0 with starve=1 for one cycle if the buffer is empty.
//  - c_k = x_k - x_k[n-N]; the delay line shifts on that tick only.
//  - Arithmetic is ACC_WIDTH two's complement, input sign-extended.
//  Upsampler: integrator-chain input = comb output on phase 0, 0 on phases 1..R_q-1.
//  Integrator section:
//  - Each stage accumulates on every out_tick: i_k <= i_k + in_k.
//  - Wraps modulo 2^ACC_WIDTH; wrap is legal and is not flagged.
//  Scaling:
//  - Gain G = (R*N)^Q / R, so SHIFT = (Q-1)*log2(R_q) + Q*log2(N).
//  - out = (i_Q + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
//  - out is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], raising overflow/underflow.
//  Latency and output registers:
//  - cic_out, valid_out, overflow and underflow are registered.
//  - valid_out pulses exactly in the cycle after each out_tick, carrying the value computed from that tick.
//  - cic_out holds between pulses.
//  Throughput:
//  - Upstream must supply one sample per R_q ticks; a late sample yields zero-insertion plus starve.
//  - out_tick back-to-back every cycle is legal.
//  Simultaneous valid_in and a phase-0 tick with an empty buffer: starve fires and 0 is used.
//  - The new sample loads for the next frame, with no bypass.
// TESTING
//  1. Q=1,N=1,R=4; buffer 0x4000 then 0x2000; 8 ticks.
//     -> cic_out 0x4000 x4 then 0x2000 x4 (zero-order hold); valid_out one cycle after each tick.
//  2. Q=2,N=1,R=2; step 0x4000 every frame, 8 ticks.
//     -> SHIFT=1; outputs 0x2000,0x4000,0x4000,...; no overflow.
//  3. Q=1,R=4, no valid_in before first tick.
//     -> starve=1 on that tick; cic_out 0x0000 for 4 ticks; ready_in remains 1.
//  4. Backpressure: valid_in held high, ticks at R=4.
//     -> ready_in low while buf_full, one sample accepted per 4 ticks, no sample lost or duplicated.
//  5. int_factor 4->2 written at phase 2.
//     -> frame finishes 4 ticks, next frame 2 ticks; int_factor=3 behaves as R=1.
//  6. Assert rst_n low mid-frame (phase 2, buffer full).
//     -> all outputs 0, ready_in 1; the next tick is phase 0 and reports starve.

Source files
------------

// File: rtl/cic_interpolator.sv
// Purpose: CIC interpolator. Q low-rate combs, a zero-stuffing upsampler by R and Q integrators.
//          Each out_tick yields one rounded, saturated sample.
// Latency: cic_out/valid_out/overflow/underflow/starve are registered, one cycle after each out_tick.
// Backpressure: a one-entry input buffer, ready_in = ~buf_full. A phase-0 tick that finds the buffer
//               empty inserts a zero and pulses starve.
// Ports: clk, rst_n (async, active-low); int_factor (R: 1,2,4,8,16, others act as 1);
//        valid_in/ready_in/cic_in (low-rate input); out_tick (high-rate strobe);
//        cic_out/valid_out/overflow/underflow/starve (high-rate output and status pulses).
module cic_interpolator #(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_FRAC      = 15,
    parameter int Q              = 1,
    parameter int N              = 1,
    parameter int MAX_INT_FACTOR = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4:0]                   int_factor,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic signed [DATA_WIDTH-1:0] cic_in,
    input  logic                         out_tick,
    output logic signed [DATA_WIDTH-1:0] cic_out,
    output logic                         valid_out,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         starve
);

    localparam int LOG_MAX = $clog2(MAX_INT_FACTOR);
    localparam int AW      = DATA_WIDTH + Q * $clog2(N * MAX_INT_FACTOR);
    localparam int PW      = (LOG_MAX > 0) ? LOG_MAX : 1;
    localparam int LW      = (LOG_MAX > 0) ? $clog2(LOG_MAX + 1) : 1;
    localparam int LOG_N   = (N == 2) ? 1 : 0;
    localparam int SW      = 8;

    // Output range limits, expressed in the widened rounding width.
    localparam logic signed [AW:0] OUT_MAX = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] OUT_MIN = {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Elaboration-time sanity checks on the parameter set.
    if (Q < 1 || Q > 4) begin : g_bad_q
        $error("cic_interpolator: Q must be 1..4");
    end
    if (N < 1 || N > 2) begin : g_bad_n
        $error("cic_interpolator: N must be 1 or 2");
    end
    if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
        $error("cic_interpolator: DATA_FRAC must be below DATA_WIDTH");
    end

    // The factor is held as log2(R). Any value that is not a supported power of two maps to 0 (R = 1).
    function automatic logic [LW-1:0] decode_factor(input logic [4:0] f);
        logic [LW-1:0] r;
        r = '0;
        for (int k = 0; k <= LOG_MAX && k < 5; k++) begin
            if (f == 5'(1 << k)) r = LW'(k);
        end
        return r;
    endfunction

    logic                         buf_full;
    logic signed [DATA_WIDTH-1:0] buf_dat;
    logic [PW-1:0]                ph;
    logic [PW-1:0]                ph_last;
    logic [PW-1:0]                ph_nxt;
    logic [LW-1:0]                lr_q;
    logic [LW-1:0]                lr_eff;
    logic                         phase0;
    logic                         load;
    logic                         consume;

    logic signed [AW-1:0] dly       [0:Q-1][0:N-1];
    logic signed [AW-1:0] comb_in   [0:Q-1];
    logic signed [AW-1:0] comb_out;
    logic signed [AW-1:0] upsample;
    logic signed [AW-1:0] integ     [0:Q-1];
    logic signed [AW-1:0] integ_nxt [0:Q-1];

    logic [SW-1:0]                shift_amt;
    logic signed [AW:0]           rounded;
    logic signed [AW:0]           scaled;
    logic                         sat_hi;
    logic                         sat_lo;
    logic signed [DATA_WIDTH-1:0] sat_val;

    assign ready_in = ~buf_full;
    assign load     = valid_in & ~buf_full;
    assign phase0   = out_tick & (ph == '0);
    assign consume  = phase0 & buf_full;

    // A new factor is taken only at a frame start. The tick that opens the frame already uses it,
    // both for the frame length and for the output scaling.
    assign lr_eff   = (ph == '0) ? decode_factor(int_factor) : lr_q;
    assign ph_last  = PW'((1 << lr_eff) - 1);
    assign ph_nxt   = (ph == ph_last) ? '0 : ph + PW'(1);

    // Comb cascade. x is the buffered sample, or zero when the buffer is starved.
    always_comb begin : p_comb
        logic signed [AW-1:0] run;
        run = buf_full ? {{(AW-DATA_WIDTH){buf_dat[DATA_WIDTH-1]}}, buf_dat} : '0;
        for (int k = 0; k < Q; k++) begin
            comb_in[k] = run;
            run        = run - dly[k][N-1];
        end
        comb_out = run;
    end

    assign upsample = phase0 ? comb_out : '0;

    // Integrator cascade. Each stage sees the freshly updated value of the stage before it, so the
    // output of a tick already includes that tick's input.
    always_comb begin : p_integ
        logic signed [AW-1:0] run;
        run = upsample;
        for (int k = 0; k < Q; k++) begin
            run          = integ[k] + run;
            integ_nxt[k] = run;
        end
    end

    // Gain (R*N)^Q / R is removed by a shift, with round-half-up. Rounding is done one bit wider
    // so that the rounding constant cannot wrap the accumulator.
    always_comb begin : p_scale
        shift_amt = SW'((Q - 1) * int'(lr_eff) + Q * LOG_N);
        rounded   = {integ_nxt[Q-1][AW-1], integ_nxt[Q-1]};
        if (shift_amt != '0) begin
            rounded = rounded + ((AW+1)'(1) << (shift_amt - SW'(1)));
        end
        scaled  = rounded >>> shift_amt;
        sat_hi  = (scaled > OUT_MAX);
        sat_lo  = (scaled < OUT_MIN);
        sat_val = scaled[DATA_WIDTH-1:0];
        if (sat_hi) sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (sat_lo) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full  <= 1'b0;
            buf_dat   <= '0;
            ph        <= '0;
            lr_q      <= '0;
            cic_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            starve    <= 1'b0;
            for (int k = 0; k < Q; k++) begin
                integ[k] <= '0;
                for (int j = 0; j < N; j++) dly[k][j] <= '0;
            end
        end else begin
            // Load and consume together: the comb reads the old entry, and the new one stays.
            if (load) buf_dat <= cic_in;
            buf_full  <= load | (buf_full & ~consume);

            valid_out <= out_tick;
            starve    <= phase0 & ~buf_full;
            overflow  <= out_tick & sat_hi;
            underflow <= out_tick & sat_lo;

            if (out_tick) begin
                ph      <= ph_nxt;
                lr_q    <= lr_eff;
                cic_out <= sat_val;
                for (int k = 0; k < Q; k++) integ[k] <= integ_nxt[k];
            end

            if (phase0) begin
                for (int k = 0; k < Q; k++) begin
                    dly[k][0] <= comb_in[k];
                    for (int j = 1; j < N; j++) dly[k][j] <= dly[k][j-1];
                end
            end
        end
    end

endmodule
